wb_pipe_reg: RTL

WB_PIPE_REG -- requirements
Module: wb_pipe_reg

---
 rtl/wb_pipe_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register with valid/ready handshake, flush and bubble counter.
// Define WB_PIPE_SKID_EN to add a one-entry skid buffer that cuts the out_ready -> in_ready path.
module wb_pipe_reg #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_aluout,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       bubble_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // valid never waits on ready; flush overrides every transfer on its edge.
  logic              out_valid_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] alu_q;
  logic [ADDR_W-1:0] rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       bubble_q;
  logic              load_out;
  logic              in_xfer;

  assign load_out = out_ready | ~out_valid_q;
  assign in_xfer  = in_valid & in_ready;

`ifdef WB_PIPE_SKID_EN
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_mem_q;
  logic [DATA_W-1:0] skid_alu_q;
  logic [ADDR_W-1:0] skid_rd_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  // Ready depends only on local state, so out_ready never reaches in_ready.
  assign in_ready = ~skid_valid_q & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      mem_q        <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_mem_q   <= '0;
      skid_alu_q   <= '0;
      skid_rd_q    <= '0;
      skid_ctrl_q  <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        // Oldest entry sits in the skid, so it goes out first.
        out_valid_q  <= 1'b1;
        mem_q        <= skid_mem_q;
        alu_q        <= skid_alu_q;
        rd_q         <= skid_rd_q;
        ctrl_q       <= skid_ctrl_q;
        skid_valid_q <= in_xfer;
        if (in_xfer) begin
          skid_mem_q  <= in_mem_data;
          skid_alu_q  <= in_aluout;
          skid_rd_q   <= in_rd_addr;
          skid_ctrl_q <= in_ctrl;
        end
      end else begin
        out_valid_q <= in_xfer;
        if (in_xfer) begin
          mem_q  <= in_mem_data;
          alu_q  <= in_aluout;
          rd_q   <= in_rd_addr;
          ctrl_q <= in_ctrl;
        end
      end
    end else if (in_xfer) begin
      skid_valid_q <= 1'b1;
      skid_mem_q   <= in_mem_data;
      skid_alu_q   <= in_aluout;
      skid_rd_q    <= in_rd_addr;
      skid_ctrl_q  <= in_ctrl;
    end
  end
`else
  assign in_ready = load_out & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      mem_q       <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_out) begin
      out_valid_q <= in_xfer;
      if (in_xfer) begin
        mem_q  <= in_mem_data;
        alu_q  <= in_aluout;
        rd_q   <= in_rd_addr;
        ctrl_q <= in_ctrl;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!out_valid_q && (bubble_q != 16'hFFFF)) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  // A bubble must never carry RegWrite or MemtoReg downstream.
  assign out_valid    = out_valid_q;
  assign out_ctrl     = out_valid_q ? ctrl_q : '0;
  assign out_mem_data = mem_q;
  assign out_aluout   = alu_q;
  assign out_rd_addr  = rd_q;
  assign bubble_cnt   = bubble_q;

endmodule
